// File: rtl/tlb.sv
// Fully-associative MIPS TLB array with two lookup ports and an invalidate-all sweep.
//   clk, resetn                : clock, asynchronous active-low reset
//   s0_* / s1_*                : lookup ports (s0 fetch, s1 data/TLBP); the results are
//                                combinational from the array
//   we, w_index, w_*           : TLBWI write port, committed on the clock edge
//   r_index, r_*               : TLBR read port, combinational
//   inv_all, inv_busy          : start pulse and busy flag of the V-bit clearing sweep
module tlb #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  // lookup port 0
  input  logic [18:0]     s0_vpn2,
  input  logic            s0_odd_page,
  input  logic [7:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic            s0_multi,
  output logic [19:0]     s0_pfn,
  output logic [2:0]      s0_c,
  output logic            s0_d,
  output logic            s0_v,
  // lookup port 1
  input  logic [18:0]     s1_vpn2,
  input  logic            s1_odd_page,
  input  logic [7:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic            s1_multi,
  output logic [19:0]     s1_pfn,
  output logic [2:0]      s1_c,
  output logic            s1_d,
  output logic            s1_v,
  // write port
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic [18:0]     w_vpn2,
  input  logic [7:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_pfn0,
  input  logic [2:0]      w_c0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_pfn1,
  input  logic [2:0]      w_c1,
  input  logic            w_d1,
  input  logic            w_v1,
  // read port
  input  logic [IDXW-1:0] r_index,
  output logic [18:0]     r_vpn2,
  output logic [7:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_pfn0,
  output logic [2:0]      r_c0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_pfn1,
  output logic [2:0]      r_c1,
  output logic            r_d1,
  output logic            r_v1,
  // invalidate-all sweep
  input  logic            inv_all,
  output logic            inv_busy
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state;
  logic [IDXW-1:0] cnt;

  logic [18:0] vpn2_q [TLBNUM];
  logic [7:0]  asid_q [TLBNUM];
  logic        g_q    [TLBNUM];
  logic [19:0] pfn0_q [TLBNUM];
  logic [2:0]  c0_q   [TLBNUM];
  logic        d0_q   [TLBNUM];
  logic        v0_q   [TLBNUM];
  logic [19:0] pfn1_q [TLBNUM];
  logic [2:0]  c1_q   [TLBNUM];
  logic        d1_q   [TLBNUM];
  logic        v1_q   [TLBNUM];

  // Sweep controller: cnt names the entry cleared on the next edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      inv_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_all) begin
            state    <= SWEEP;
            cnt      <= '0;
            inv_busy <= 1'b1;
          end
        end
        SWEEP: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDXW'(TLBNUM - 1)) begin
            state    <= IDLE;
            inv_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          inv_busy <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage. Indices >= TLBNUM never match the loop, so such writes drop out.
  // A write to the entry under the sweep counter takes priority over the clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        g_q[i]    <= 1'b0;
        pfn0_q[i] <= '0;
        c0_q[i]   <= '0;
        d0_q[i]   <= 1'b0;
        v0_q[i]   <= 1'b0;
        pfn1_q[i] <= '0;
        c1_q[i]   <= '0;
        d1_q[i]   <= 1'b0;
        v1_q[i]   <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        if (we && w_index == IDXW'(i)) begin
          vpn2_q[i] <= w_vpn2;
          asid_q[i] <= w_asid;
          g_q[i]    <= w_g;
          pfn0_q[i] <= w_pfn0;
          c0_q[i]   <= w_c0;
          d0_q[i]   <= w_d0;
          v0_q[i]   <= w_v0;
          pfn1_q[i] <= w_pfn1;
          c1_q[i]   <= w_c1;
          d1_q[i]   <= w_d1;
          v1_q[i]   <= w_v1;
        end else if (state == SWEEP && cnt == IDXW'(i)) begin
          v0_q[i] <= 1'b0;
          v1_q[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [IDXW-1:0] lowest(input logic [TLBNUM-1:0] m);
    logic hit;
    lowest = '0;
    hit    = 1'b0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      if (m[i] && !hit) begin
        lowest = IDXW'(i);
        hit    = 1'b1;
      end
    end
  endfunction

  logic [TLBNUM-1:0] m0, m1;

  always_comb begin
    m0 = '0;
    m1 = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      m0[i] = (vpn2_q[i] == s0_vpn2) && (g_q[i] || asid_q[i] == s0_asid);
      m1[i] = (vpn2_q[i] == s1_vpn2) && (g_q[i] || asid_q[i] == s1_asid);
    end
  end

  assign s0_found = |m0;
  assign s1_found = |m1;
  assign s0_index = lowest(m0);
  assign s1_index = lowest(m1);
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign s0_multi = |(m0 & (m0 - TLBNUM'(1)));
  assign s1_multi = |(m1 & (m1 - TLBNUM'(1)));

  always_comb begin
    s0_pfn = '0;
    s0_c   = '0;
    s0_d   = 1'b0;
    s0_v   = 1'b0;
    if (s0_found) begin
      if (s0_odd_page) begin
        s0_pfn = pfn1_q[s0_index];
        s0_c   = c1_q[s0_index];
        s0_d   = d1_q[s0_index];
        s0_v   = v1_q[s0_index];
      end else begin
        s0_pfn = pfn0_q[s0_index];
        s0_c   = c0_q[s0_index];
        s0_d   = d0_q[s0_index];
        s0_v   = v0_q[s0_index];
      end
    end
  end

  always_comb begin
    s1_pfn = '0;
    s1_c   = '0;
    s1_d   = 1'b0;
    s1_v   = 1'b0;
    if (s1_found) begin
      if (s1_odd_page) begin
        s1_pfn = pfn1_q[s1_index];
        s1_c   = c1_q[s1_index];
        s1_d   = d1_q[s1_index];
        s1_v   = v1_q[s1_index];
      end else begin
        s1_pfn = pfn0_q[s1_index];
        s1_c   = c0_q[s1_index];
        s1_d   = d0_q[s1_index];
        s1_v   = v0_q[s1_index];
      end
    end
  end

  always_comb begin
    r_vpn2 = '0;
    r_asid = '0;
    r_g    = 1'b0;
    r_pfn0 = '0;
    r_c0   = '0;
    r_d0   = 1'b0;
    r_v0   = 1'b0;
    r_pfn1 = '0;
    r_c1   = '0;
    r_d1   = 1'b0;
    r_v1   = 1'b0;
    if (32'(r_index) < 32'(TLBNUM)) begin
      r_vpn2 = vpn2_q[r_index];
      r_asid = asid_q[r_index];
      r_g    = g_q[r_index];
      r_pfn0 = pfn0_q[r_index];
      r_c0   = c0_q[r_index];
      r_d0   = d0_q[r_index];
      r_v0   = v0_q[r_index];
      r_pfn1 = pfn1_q[r_index];
      r_c1   = c1_q[r_index];
      r_d1   = d1_q[r_index];
      r_v1   = v1_q[r_index];
    end
  end

endmodule

// File: tb/tb_tlb.sv
module tb_tlb;

  logic        clk;
  logic        resetn;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic        s0_multi, s1_multi;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_d1, w_v0, w_v1;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_d1, r_v0, r_v1;
  logic        inv_all;
  logic        inv_busy;

  int n_checks;
  int n_pass;
  int busy_cycles;

  tlb #(.TLBNUM(16), .IDXW(4)) dut (
    .clk(clk), .resetn(resetn),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_multi(s0_multi),
    .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_multi(s1_multi),
    .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .inv_all(inv_all), .inv_busy(inv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents a write for one clock edge; call just after a rising edge.
  task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                    input logic g, input logic [19:0] pfn0, input logic v0,
                    input logic [19:0] pfn1, input logic [2:0] c1, input logic d1,
                    input logic v1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = 3'd0; w_d0 = 1'b0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic look1(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
    s1_vpn2 = vpn2; s1_asid = asid; s1_odd_page = odd;
    #1;
  endtask

  task automatic look0(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
    s0_vpn2 = vpn2; s0_asid = asid; s0_odd_page = odd;
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    resetn = 1'b0; inv_all = 1'b0; we = 1'b0; r_index = '0;
    w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    s0_vpn2 = 19'h12345; s0_asid = 8'h05; s0_odd_page = 1'b0;
    s1_vpn2 = '0; s1_asid = '0; s1_odd_page = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_s0_found", 32'(s0_found), 32'd0);
    chk("rst_s0_index", 32'(s0_index), 32'd0);
    chk("rst_s0_pfn", 32'(s0_pfn), 32'd0);
    chk("rst_inv_busy", 32'(inv_busy), 32'd0);
    look0(19'h0, 8'h00, 1'b0);
    chk("rst_zero_tag_found", 32'(s0_found), 32'd1);
    chk("rst_zero_tag_v", 32'(s0_v), 32'd0);

    // Basic write; no same-cycle bypass
    look1(19'h12345, 8'h05, 1'b0);
    we = 1'b1; w_index = 4'd3; w_vpn2 = 19'h12345; w_asid = 8'h05; w_g = 1'b0;
    w_pfn0 = 20'hABCDE; w_v0 = 1'b1; #1;
    chk("no_bypass_found", 32'(s1_found), 32'd0);
    @(posedge clk); #1; we = 1'b0;
    chk("t2_found", 32'(s1_found), 32'd1);
    chk("t2_index", 32'(s1_index), 32'd3);
    chk("t2_pfn", 32'(s1_pfn), 32'hABCDE);
    chk("t2_v", 32'(s1_v), 32'd1);
    chk("t2_multi", 32'(s1_multi), 32'd0);
    look1(19'h12345, 8'h06, 1'b0);
    chk("t2_asid_miss", 32'(s1_found), 32'd0);
    chk("t2_miss_pfn", 32'(s1_pfn), 32'd0);

    // TLBR
    r_index = 4'd3; #1;
    chk("t4_r_vpn2", 32'(r_vpn2), 32'h12345);
    chk("t4_r_asid", 32'(r_asid), 32'h05);
    chk("t4_r_pfn0", 32'(r_pfn0), 32'hABCDE);
    chk("t4_r_v0", 32'(r_v0), 32'd1);
    chk("t4_r_pfn1", 32'(r_pfn1), 32'd0);
    chk("t4_r_g", 32'(r_g), 32'd0);

    // Global bit, multi match, odd page
    @(posedge clk); #1;
    wr(4'd3, 19'h12345, 8'h05, 1'b1, 20'hABCDE, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    look1(19'h12345, 8'h06, 1'b0);
    chk("t3_global_found", 32'(s1_found), 32'd1);
    chk("t3_global_index", 32'(s1_index), 32'd3);
    wr(4'd1, 19'h12345, 8'h07, 1'b0, 20'h22222, 1'b0, 20'h11111, 3'd3, 1'b1, 1'b1);
    look1(19'h12345, 8'h07, 1'b1);
    chk("t3_multi_index", 32'(s1_index), 32'd1);
    chk("t3_multi", 32'(s1_multi), 32'd1);
    chk("t3_odd_pfn", 32'(s1_pfn), 32'h11111);
    chk("t3_odd_c", 32'(s1_c), 32'd3);
    chk("t3_odd_d", 32'(s1_d), 32'd1);
    chk("t3_odd_v", 32'(s1_v), 32'd1);
    look0(19'h12345, 8'h07, 1'b0);
    chk("t3_s0_index", 32'(s0_index), 32'd1);
    chk("t3_s0_pfn", 32'(s0_pfn), 32'h22222);
    chk("t3_s0_v", 32'(s0_v), 32'd0);

    // Fill all entries, then sweep
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++)
      wr(4'(i), 19'(32'h100 + i), 8'(i), 1'b0, 20'(32'h1000 + i), 1'b1,
         20'(32'h2000 + i), 3'd0, 1'b0, 1'b1);
    @(negedge clk) inv_all = 1'b1;
    @(posedge clk); #1; inv_all = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 40 && inv_busy; k++) begin
      busy_cycles++;
      if (k == 3) inv_all = 1'b1;
      if (k == 5) begin
        look0(19'h104, 8'h04, 1'b0);
        chk("mid_cleared_found", 32'(s0_found), 32'd1);
        chk("mid_cleared_v", 32'(s0_v), 32'd0);
        look0(19'h105, 8'h05, 1'b0);
        chk("mid_pending_v", 32'(s0_v), 32'd1);
      end
      if (k == 9) begin
        we = 1'b1; w_index = 4'd9; w_vpn2 = 19'h109; w_asid = 8'h09; w_g = 1'b0;
        w_pfn0 = 20'h99999; w_v0 = 1'b1; w_pfn1 = 20'h2009; w_v1 = 1'b0;
      end
      @(posedge clk); #1;
      inv_all = 1'b0; we = 1'b0;
    end
    chk("sweep_len", 32'(busy_cycles), 32'd16);
    chk("sweep_done_busy", 32'(inv_busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i); #1;
      chk($sformatf("sw_v0_%0d", i), 32'(r_v0), (i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("sw_v1_%0d", i), 32'(r_v1), 32'd0);
      chk($sformatf("sw_vpn2_%0d", i), 32'(r_vpn2), 32'h100 + i);
    end
    r_index = 4'd9; #1;
    chk("sw_w9_pfn0", 32'(r_pfn0), 32'h99999);

    // Reset in the middle of a sweep
    @(posedge clk); #1;
    wr(4'd2, 19'h202, 8'h02, 1'b0, 20'h3, 1'b1, 20'h4, 3'd0, 1'b0, 1'b1);
    @(negedge clk) inv_all = 1'b1;
    @(posedge clk); #1; inv_all = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_abort_busy", 32'(inv_busy), 32'd1);
    resetn = 1'b0; #1;
    chk("abort_busy", 32'(inv_busy), 32'd0);
    @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i); #1;
      chk($sformatf("rst_r_vpn2_%0d", i), 32'(r_vpn2), 32'd0);
      chk($sformatf("rst_r_pfn0_%0d", i), 32'(r_pfn0), 32'd0);
      chk($sformatf("rst_r_v1_%0d", i), 32'(r_v1), 32'd0);
    end
    look0(19'h202, 8'h02, 1'b0);
    chk("rst_s0_miss", 32'(s0_found), 32'd0);

    // New sweep starts from entry 0
    @(posedge clk); #1;
    wr(4'd0, 19'h300, 8'h01, 1'b0, 20'h5, 1'b1, 20'h6, 3'd0, 1'b0, 1'b1);
    r_index = 4'd0;
    @(negedge clk) inv_all = 1'b1;
    @(posedge clk); #1; inv_all = 1'b0;
    chk("restart_busy", 32'(inv_busy), 32'd1);
    chk("restart_e0_before", 32'(r_v0), 32'd1);
    @(posedge clk); #1;
    chk("restart_e0_v0", 32'(r_v0), 32'd0);
    chk("restart_e0_v1", 32'(r_v1), 32'd0);
    busy_cycles = 0;
    for (int k = 0; k < 40 && inv_busy; k++) begin
      busy_cycles++;
      @(posedge clk); #1;
    end
    chk("restart_remaining", 32'(busy_cycles), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
